// File: rtl/multicycle_main_control_if.sv
// Interface bundle between the multi-cycle main control FSM and the MIPS datapath.
// The master side (the controller) takes in the opcode and memory handshake and drives every control line.
interface multicycle_main_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic       reg_dst;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state_o;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, state_o
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, state_o
  );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multi-cycle MIPS datapath (fetch/decode/execute/memory/writeback).
// Define ADDI_SUPPORT_EN to add the addi path (states 11/12); otherwise addi decodes as illegal.
module multicycle_main_control #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic                          clk,
  input  logic                          rstn,
  multicycle_main_control_if.master     bus
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_RD    = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WR    = 4'd6,
    EXEC      = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    ADDI_EXEC = 4'd11,
    ADDI_WB   = 4'd12
  } state_t;

  state_t state;
  state_t state_next;
  logic   is_store;
  logic   illegal;

  // lw/sw choice is captured in DECODE so opcode changes later are ignored
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      is_store <= 1'b0;
    end else begin
      state <= state_next;
      if (state == DECODE) is_store <= (bus.opcode == OP_SW);
    end
  end

  assign bus.state_o = state;

  always_comb begin
    state_next        = IDLE;
    illegal           = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_source     = 2'b00;
    bus.instr_done    = 1'b0;
    bus.illegal_op    = 1'b0;

    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        state_next    = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_next = MEM_ADDR;
          OP_RTYPE:     state_next = EXEC;
          OP_BEQ:       state_next = BRANCH;
          OP_J:         state_next = JUMP;
`ifdef ADDI_SUPPORT_EN
          OP_ADDI:      state_next = ADDI_EXEC;
`else
          OP_ADDI:      illegal    = 1'b1;
`endif
          default:      illegal    = 1'b1;
        endcase
        if (illegal) begin
          bus.illegal_op = 1'b1;
          bus.instr_done = 1'b1;
          state_next     = FETCH;
        end
      end
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_next    = is_store ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        state_next   = bus.mem_ready ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
        state_next     = FETCH;
      end
      MEM_WR: begin
        bus.mem_write  = 1'b1;
        bus.i_or_d     = 1'b1;
        bus.instr_done = bus.mem_ready;
        state_next     = bus.mem_ready ? FETCH : MEM_WR;
      end
      EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        state_next    = R_WB;
      end
      R_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 1'b1;
        bus.instr_done = 1'b1;
        state_next     = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        bus.instr_done    = 1'b1;
        state_next        = FETCH;
      end
      JUMP: begin
        bus.pc_write   = 1'b1;
        bus.pc_source  = 2'b10;
        bus.instr_done = 1'b1;
        state_next     = FETCH;
      end
`ifdef ADDI_SUPPORT_EN
      ADDI_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_next    = ADDI_WB;
      end
      ADDI_WB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        state_next     = FETCH;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control: per-instruction expected state/control traces
// are built from the instruction step lists, with random stalls and random off-DECODE opcodes.
module tb_multicycle_main_control;

  logic clk = 1'b0;
  logic rstn;
  multicycle_main_control_if bus ();

  multicycle_main_control dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  typedef struct {
    int st;
    bit rdy;
    bit ill;
  } step_t;

  step_t      plan[$];
  logic [3:0] obs_st[$];
  ctl_t       obs_w[$];
  int obs_lat, obs_regw, obs_memw, obs_both, obs_ill;
  int exp_lat, exp_regw, exp_memw, exp_ill;
  int errors = 0;
  int checks = 0;

  function automatic ctl_t observe();
    ctl_t c;
    c = '{pc_write: bus.pc_write, pc_write_cond: bus.pc_write_cond, i_or_d: bus.i_or_d,
          mem_read: bus.mem_read, mem_write: bus.mem_write, ir_write: bus.ir_write,
          mem_to_reg: bus.mem_to_reg, reg_write: bus.reg_write, reg_dst: bus.reg_dst,
          alu_src_a: bus.alu_src_a, alu_src_b: bus.alu_src_b, alu_op: bus.alu_op,
          pc_source: bus.pc_source, instr_done: bus.instr_done, illegal_op: bus.illegal_op};
    return c;
  endfunction

  // Control word demanded by the datapath in each numbered step
  function automatic ctl_t expect_ctl(int st, bit rdy, bit ill);
    ctl_t c = '0;
    case (st)
      1:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      2:  begin c.alu_src_b = 2'b11; c.illegal_op = ill; c.instr_done = ill; end
      3:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      4:  begin c.mem_read = 1; c.i_or_d = 1; end
      5:  begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; end
      6:  begin c.mem_write = 1; c.i_or_d = 1; c.instr_done = rdy; end
      7:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      8:  begin c.reg_write = 1; c.reg_dst = 1; c.instr_done = 1; end
      9:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; c.instr_done = 1; end
      10: begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1; end
      11: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      12: begin c.reg_write = 1; c.instr_done = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic bit is_illegal(logic [5:0] op);
    case (op)
      6'h00, 6'h23, 6'h2B, 6'h04, 6'h02: return 1'b0;
`ifdef ADDI_SUPPORT_EN
      6'h08: return 1'b0;
`endif
      default: return 1'b1;
    endcase
  endfunction

  // Builds the step list and the independent latency/write-count expectations
  task automatic build_plan(input logic [5:0] op, input int fs, input int ms);
    bit ill;
    ill = is_illegal(op);
    plan.delete();
    repeat (fs) plan.push_back('{st: 1, rdy: 1'b0, ill: 1'b0});
    plan.push_back('{st: 1, rdy: 1'b1, ill: 1'b0});
    plan.push_back('{st: 2, rdy: 1'($urandom), ill: ill});
    exp_lat = 2 + fs; exp_regw = 0; exp_memw = 0; exp_ill = ill ? 1 : 0;
    if (!ill) begin
      case (op)
        6'h00: begin
          plan.push_back('{st: 7, rdy: 1'($urandom), ill: 1'b0});
          plan.push_back('{st: 8, rdy: 1'($urandom), ill: 1'b0});
          exp_lat = 4 + fs; exp_regw = 1;
        end
        6'h23: begin
          plan.push_back('{st: 3, rdy: 1'($urandom), ill: 1'b0});
          repeat (ms) plan.push_back('{st: 4, rdy: 1'b0, ill: 1'b0});
          plan.push_back('{st: 4, rdy: 1'b1, ill: 1'b0});
          plan.push_back('{st: 5, rdy: 1'($urandom), ill: 1'b0});
          exp_lat = 5 + fs + ms; exp_regw = 1;
        end
        6'h2B: begin
          plan.push_back('{st: 3, rdy: 1'($urandom), ill: 1'b0});
          repeat (ms) plan.push_back('{st: 6, rdy: 1'b0, ill: 1'b0});
          plan.push_back('{st: 6, rdy: 1'b1, ill: 1'b0});
          exp_lat = 4 + fs + ms; exp_memw = ms + 1;
        end
        6'h04: begin
          plan.push_back('{st: 9, rdy: 1'($urandom), ill: 1'b0});
          exp_lat = 3 + fs;
        end
        6'h02: begin
          plan.push_back('{st: 10, rdy: 1'($urandom), ill: 1'b0});
          exp_lat = 3 + fs;
        end
        default: begin
          plan.push_back('{st: 11, rdy: 1'($urandom), ill: 1'b0});
          plan.push_back('{st: 12, rdy: 1'($urandom), ill: 1'b0});
          exp_lat = 4 + fs; exp_regw = 1;
        end
      endcase
    end
  endtask

  // Entered at posedge+1 with the DUT in FETCH; leaves the same way after the instruction.
  task automatic run_instr(input logic [5:0] op, input int fs, input int ms);
    ctl_t w;
    build_plan(op, fs, ms);
    obs_st.delete(); obs_w.delete();
    obs_lat = 0; obs_regw = 0; obs_memw = 0; obs_both = 0; obs_ill = 0;
    foreach (plan[i]) begin
      bus.opcode    = (plan[i].st == 2) ? op : 6'($urandom);
      bus.mem_ready = plan[i].rdy;
      @(negedge clk);
      w = observe();
      obs_st.push_back(bus.state_o);
      obs_w.push_back(w);
      if (w.instr_done && obs_lat == 0) obs_lat = i + 1;
      obs_regw += w.reg_write;
      obs_memw += w.mem_write;
      obs_both += (w.mem_read & w.mem_write);
      obs_ill  += w.illegal_op;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; bus.opcode = '0; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.state_o !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state_o); end
    checks++; if (observe() !== ctl_t'('0)) begin errors++; $display("FAIL reset_outputs: got %h want 0", observe()); end
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (bus.state_o !== 4'd0 || observe() !== ctl_t'('0)) begin
      errors++; $display("FAIL post_reset_idle: state %0d ctl %h want 0/0", bus.state_o, observe()); end
    @(posedge clk); #1;
    checks++; if (bus.state_o !== 4'd1 || bus.mem_read !== 1'b1) begin
      errors++; $display("FAIL post_reset_fetch: state %0d mem_read %b want 1/1", bus.state_o, bus.mem_read); end
  endtask

  task automatic test_reset_mid_exec();
    bus.opcode = 6'h00; bus.mem_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (bus.state_o !== 4'd7) begin errors++; $display("FAIL mid_exec_reach: state %0d want 7", bus.state_o); end
    rstn = 1'b0; #1;
    checks++; if (bus.state_o !== 4'd0 || observe() !== ctl_t'('0)) begin
      errors++; $display("FAIL async_reset: state %0d ctl %h want 0/0", bus.state_o, observe()); end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (bus.state_o !== 4'd0 || bus.reg_write !== 1'b0 || bus.mem_write !== 1'b0) begin
      errors++; $display("FAIL mid_reset_idle: state %0d reg_write %b mem_write %b want 0/0/0", bus.state_o, bus.reg_write, bus.mem_write); end
    @(posedge clk); #1;
    checks++; if (observe() !== expect_ctl(1, 1'b1, 1'b0) || bus.state_o !== 4'd1) begin
      errors++; $display("FAIL mid_reset_fetch: state %0d ctl %h want 1/%h", bus.state_o, observe(), expect_ctl(1, 1'b1, 1'b0)); end
  endtask

  task automatic test_rtype();
    run_instr(6'h00, 0, 0);
    foreach (plan[i]) begin
      checks++; if (obs_st[i] !== 4'(plan[i].st)) begin errors++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, obs_st[i], plan[i].st); end
      checks++; if (obs_w[i] !== expect_ctl(plan[i].st, plan[i].rdy, plan[i].ill)) begin
        errors++; $display("FAIL rtype_ctl[%0d]: got %h want %h", i, obs_w[i], expect_ctl(plan[i].st, plan[i].rdy, plan[i].ill)); end
    end
    checks++; if (obs_lat !== 4 || obs_regw !== 1) begin errors++; $display("FAIL rtype_latency: lat %0d regw %0d want 4/1", obs_lat, obs_regw); end
  endtask

  task automatic test_lw_stalls();
    run_instr(6'h23, 2, 3);
    foreach (plan[i]) begin
      checks++; if (obs_st[i] !== 4'(plan[i].st)) begin errors++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, obs_st[i], plan[i].st); end
      checks++; if (obs_w[i] !== expect_ctl(plan[i].st, plan[i].rdy, plan[i].ill)) begin
        errors++; $display("FAIL lw_ctl[%0d]: got %h want %h", i, obs_w[i], expect_ctl(plan[i].st, plan[i].rdy, plan[i].ill)); end
    end
    checks++; if (obs_lat !== 10 || obs_regw !== 1 || obs_w[9].mem_to_reg !== 1'b1) begin
      errors++; $display("FAIL lw_totals: lat %0d regw %0d m2r %b want 10/1/1", obs_lat, obs_regw, obs_w[9].mem_to_reg); end
  endtask

  task automatic test_sw_beq();
    run_instr(6'h2B, 0, 2);
    foreach (plan[i]) begin
      checks++; if (obs_st[i] !== 4'(plan[i].st) || obs_w[i] !== expect_ctl(plan[i].st, plan[i].rdy, plan[i].ill)) begin
        errors++; $display("FAIL sw_step[%0d]: got %0d/%h want %0d/%h", i, obs_st[i], obs_w[i], plan[i].st, expect_ctl(plan[i].st, plan[i].rdy, plan[i].ill)); end
    end
    checks++; if (obs_lat !== 6 || obs_regw !== 0 || obs_memw !== 3) begin
      errors++; $display("FAIL sw_totals: lat %0d regw %0d memw %0d want 6/0/3", obs_lat, obs_regw, obs_memw); end
    run_instr(6'h04, 0, 0);
    checks++; if (obs_lat !== 3 || obs_w[2].alu_op !== 2'b01 || obs_w[2].pc_write_cond !== 1'b1 || obs_w[2].pc_source !== 2'b01) begin
      errors++; $display("FAIL beq: lat %0d alu_op %b pwc %b pcs %b want 3/01/1/01", obs_lat, obs_w[2].alu_op, obs_w[2].pc_write_cond, obs_w[2].pc_source); end
  endtask

  task automatic test_jump_illegal();
    run_instr(6'h02, 0, 0);
    checks++; if (obs_lat !== 3 || obs_st[2] !== 4'd10 || obs_w[2].pc_write !== 1'b1 || obs_w[2].pc_source !== 2'b10) begin
      errors++; $display("FAIL jump: lat %0d st %0d pcw %b pcs %b want 3/10/1/10", obs_lat, obs_st[2], obs_w[2].pc_write, obs_w[2].pc_source); end
    run_instr(6'h3F, 1, 0);
    checks++; if (obs_ill !== 1 || obs_lat !== 3 || obs_w[2].illegal_op !== 1'b1 || obs_regw !== 0 || obs_memw !== 0) begin
      errors++; $display("FAIL illegal: ill %0d lat %0d regw %0d memw %0d want 1/3/0/0", obs_ill, obs_lat, obs_regw, obs_memw); end
    checks++; if (bus.state_o !== 4'd1) begin errors++; $display("FAIL illegal_next: state %0d want 1", bus.state_o); end
  endtask

  task automatic test_addi();
    run_instr(6'h08, 0, 0);
`ifdef ADDI_SUPPORT_EN
    checks++; if (obs_lat !== 4 || obs_st[3] !== 4'd12 || obs_w[3].reg_write !== 1'b1 || obs_w[3].reg_dst !== 1'b0) begin
      errors++; $display("FAIL addi: lat %0d st %0d rw %b rd %b want 4/12/1/0", obs_lat, obs_st[3], obs_w[3].reg_write, obs_w[3].reg_dst); end
`else
    checks++; if (obs_ill !== 1 || obs_lat !== 2 || obs_regw !== 0) begin
      errors++; $display("FAIL addi_illegal: ill %0d lat %0d regw %0d want 1/2/0", obs_ill, obs_lat, obs_regw); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [8];
    logic [5:0] op;
    int fs, ms;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h11};
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) op = 6'($urandom);
      fs = $urandom_range(0, 3);
      ms = $urandom_range(0, 3);
      run_instr(op, fs, ms);
      foreach (plan[i]) begin
        checks++; if (obs_st[i] !== 4'(plan[i].st) || obs_w[i] !== expect_ctl(plan[i].st, plan[i].rdy, plan[i].ill)) begin
          errors++; $display("FAIL b2b[%0d] op %h step %0d: got %0d/%h want %0d/%h", n, op, i, obs_st[i], obs_w[i], plan[i].st, expect_ctl(plan[i].st, plan[i].rdy, plan[i].ill)); end
      end
      checks++; if (obs_lat !== exp_lat || obs_regw !== exp_regw || obs_memw !== exp_memw || obs_ill !== exp_ill || obs_both !== 0) begin
        errors++; $display("FAIL b2b_totals[%0d] op %h: lat %0d regw %0d memw %0d ill %0d both %0d want %0d/%0d/%0d/%0d/0",
                           n, op, obs_lat, obs_regw, obs_memw, obs_ill, obs_both, exp_lat, exp_regw, exp_memw, exp_ill); end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stalls();
    test_sw_beq();
    test_jump_illegal();
    test_addi();
    test_back_to_back();
    test_reset_mid_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
